// File: rtl/jk_register_counter.sv
// rtl/jk_register_counter.sv - WIDTH-bit JK register bank doubling as a modulo up/down counter and load register
module jk_register_counter #(
  parameter int WIDTH       = 8,
  parameter int MODULUS     = 256,
  parameter int RESET_VALUE = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_j,
  input  logic [WIDTH-1:0] i_k,
  input  logic [WIDTH-1:0] i_load_val,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_wrap
);

  localparam logic [1:0] LP_MODE_JK   = 2'b00;
  localparam logic [1:0] LP_MODE_UP   = 2'b01;
  localparam logic [1:0] LP_MODE_DOWN = 2'b10;

  localparam logic [WIDTH-1:0] LP_MAX = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LP_RST = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH:0]   LP_MOD = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;

  logic             w_at_top;
  logic             w_is_zero;
  logic             w_in_range;
  logic [WIDTH-1:0] w_jk;
  logic [WIDTH-1:0] w_next;
  logic             w_next_wrap;

  assign w_at_top   = (r_q >= LP_MAX);
  assign w_is_zero  = (r_q == '0);
  // One extra bit so MODULUS == 2**WIDTH makes every value in range.
  assign w_in_range = ({1'b0, r_q} < LP_MOD);

  // j=1,k=1 toggles, j=1 alone sets, k=1 alone clears, neither holds.
  assign w_jk = (r_q & ~i_k) | (~r_q & i_j);

  always_comb begin
    w_next      = r_q;
    w_next_wrap = 1'b0;
    case (i_mode)
      LP_MODE_JK: begin
        w_next = w_jk;
      end
      LP_MODE_UP: begin
        if (w_at_top) begin
          w_next      = '0;
          w_next_wrap = 1'b1;
        end else begin
          w_next = r_q + 1'b1;
        end
      end
      LP_MODE_DOWN: begin
        if (w_is_zero) begin
          w_next      = LP_MAX;
          w_next_wrap = 1'b1;
        end else if (!w_in_range) begin
          // Out-of-range recovery is not counted as a wrap.
          w_next = LP_MAX;
        end else begin
          w_next = r_q - 1'b1;
        end
      end
      default: begin
        w_next = i_load_val;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q    <= LP_RST;
      r_wrap <= 1'b0;
    end else if (i_en) begin
      r_q    <= w_next;
      r_wrap <= w_next_wrap;
    end else begin
      r_wrap <= 1'b0;
    end
  end

  // Ignores i_en: flags that the next enabled count edge will wrap.
  assign o_tc   = ((i_mode == LP_MODE_UP) && w_at_top) ||
                  ((i_mode == LP_MODE_DOWN) && w_is_zero);
  assign o_q    = r_q;
  assign o_wrap = r_wrap;

endmodule

// File: tb/tb_jk_register_counter.sv
// tb/tb_jk_register_counter.sv - checks jk_register_counter against an integer model for three parameter sets
module tb_jk_register_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] j = 8'h00;
  logic [7:0] k = 8'h00;
  logic [7:0] lv = 8'h00;

  logic [7:0] q256, q10;
  logic [0:0] q2;
  logic       tc256, tc10, tc2;
  logic       wr256, wr10, wr2;

  int n_pass = 0;
  int n_total = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  jk_register_counter #(.WIDTH(8), .MODULUS(256), .RESET_VALUE(0)) u_m256 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_j(j), .i_k(k),
    .i_load_val(lv), .o_q(q256), .o_tc(tc256), .o_wrap(wr256));

  jk_register_counter #(.WIDTH(8), .MODULUS(10), .RESET_VALUE(3)) u_m10 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_j(j), .i_k(k),
    .i_load_val(lv), .o_q(q10), .o_tc(tc10), .o_wrap(wr10));

  jk_register_counter #(.WIDTH(1), .MODULUS(2), .RESET_VALUE(0)) u_m2 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_j(j[0:0]), .i_k(k[0:0]),
    .i_load_val(lv[0:0]), .o_q(q2), .o_tc(tc2), .o_wrap(wr2));

  // Model parameters per instance: 0 = M256, 1 = M10, 2 = M2.
  int unsigned p_mod [3] = '{256, 10, 2};
  int          p_w   [3] = '{8, 8, 1};
  int unsigned p_rv  [3] = '{0, 3, 0};
  int unsigned mq [3];
  bit          mw [3];

  function automatic int unsigned model_next(input int unsigned q, input logic [1:0] m,
      input logic [7:0] jj, input logic [7:0] kk, input logic [7:0] ll,
      input int unsigned modulus, input int w, output bit wr);
    int unsigned res;
    wr = 1'b0;
    res = q;
    case (m)
      2'd0: begin
        res = 0;
        for (int b = 0; b < w; b++) begin
          bit qb;
          qb = q[b];
          if (jj[b] && kk[b])      res[b] = !qb;
          else if (jj[b])          res[b] = 1'b1;
          else if (kk[b])          res[b] = 1'b0;
          else                     res[b] = qb;
        end
      end
      2'd1: begin
        if (q >= modulus - 1) begin res = 0; wr = 1'b1; end
        else res = q + 1;
      end
      2'd2: begin
        if (q == 0) begin res = modulus - 1; wr = 1'b1; end
        else if (q >= modulus) res = modulus - 1;
        else res = q - 1;
      end
      default: res = int'(ll) % (1 << w);
    endcase
    return res;
  endfunction

  function automatic bit model_tc(input int unsigned q, input logic [1:0] m, input int unsigned modulus);
    return ((m == 2'd1) && (q >= modulus - 1)) || ((m == 2'd2) && (q == 0));
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit wr;
      if (rst) begin
        mq[i] = p_rv[i];
        mw[i] = 1'b0;
      end else if (!en) begin
        mw[i] = 1'b0;
      end else begin
        mq[i] = model_next(mq[i], mode, j, k, lv, p_mod[i], p_w[i], wr);
        mw[i] = wr;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      int aq [3];
      bit at [3];
      bit aw [3];
      aq[0] = int'(q256); at[0] = tc256; aw[0] = wr256;
      aq[1] = int'(q10);  at[1] = tc10;  aw[1] = wr10;
      aq[2] = int'(q2);   at[2] = tc2;   aw[2] = wr2;
      if ($isunknown({q256, q10, q2, tc256, tc10, tc2, wr256, wr10, wr2})) begin
        n_total++;
        $display("FAIL x_on_outputs: got unknown value at %0t expected known", $time);
      end
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("model_q[%0d]", i), aq[i], int'(mq[i]));
        chk($sformatf("model_tc[%0d]", i), int'(at[i]), int'(model_tc(mq[i], mode, p_mod[i])));
        chk($sformatf("model_wrap[%0d]", i), int'(aw[i]), int'(mw[i]));
      end
    end
  end

  task automatic step(input logic r, input logic e, input logic [1:0] m,
      input logic [7:0] jj, input logic [7:0] kk, input logic [7:0] ll);
    rst = r; en = e; mode = m; j = jj; k = kk; lv = ll;
    @(posedge clk);
    #2;
  endtask

  initial begin
    // Reset values
    step(1, 0, 2'd0, 8'h00, 8'h00, 8'h00);
    chk_on = 1'b1;
    chk("reset_q256", int'(q256), 0);
    chk("reset_q10", int'(q10), 3);
    chk("reset_wrap10", int'(wr10), 0);

    // Reset overrides an enabled count
    step(0, 1, 2'd3, 8'h00, 8'h00, 8'hA5);
    chk("load_a5", int'(q256), 'hA5);
    step(1, 1, 2'd1, 8'h00, 8'h00, 8'h00);
    chk("rst_over_count_q", int'(q256), 0);
    chk("rst_over_count_wrap", int'(wr256), 0);
    step(0, 1, 2'd1, 8'hxx, 8'hxx, 8'hxx);
    chk("resume_q256", int'(q256), 1);
    chk("resume_q10", int'(q10), 4);

    // JK bitwise, then hold
    step(0, 1, 2'd3, 8'h00, 8'h00, 8'hCA);
    step(0, 1, 2'd0, 8'hA5, 8'h66, 8'hxx);
    chk("jk_q256", int'(q256), 'hAD);
    chk("jk_q10_unclamped", int'(q10), 'hAD);
    for (int c = 0; c < 3; c++) begin
      step(0, 0, 2'd0, 8'hFF, 8'hFF, 8'hxx);
      chk("hold_q256", int'(q256), 'hAD);
    end

    // Up wrap at MODULUS=10 with X on unused inputs
    step(0, 1, 2'd3, 8'h00, 8'h00, 8'd8);
    step(0, 1, 2'd1, 8'hxx, 8'hxx, 8'hxx);
    chk("up_q10_9", int'(q10), 9);
    chk("up_tc10", int'(tc10), 1);
    step(0, 1, 2'd1, 8'hxx, 8'hxx, 8'hxx);
    chk("up_wrap_q10", int'(q10), 0);
    chk("up_wrap10", int'(wr10), 1);
    step(0, 1, 2'd1, 8'hxx, 8'hxx, 8'hxx);
    chk("up_after_q10", int'(q10), 1);
    chk("up_after_wrap10", int'(wr10), 0);

    // Down wrap from zero
    step(0, 1, 2'd3, 8'h00, 8'h00, 8'd0);
    step(0, 0, 2'd2, 8'h00, 8'h00, 8'h00);
    chk("down_tc10", int'(tc10), 1);
    chk("down_tc256", int'(tc256), 1);
    step(0, 1, 2'd2, 8'h00, 8'h00, 8'h00);
    chk("down_q10", int'(q10), 9);
    chk("down_wrap10", int'(wr10), 1);
    chk("down_q256", int'(q256), 255);
    chk("down_wrap256", int'(wr256), 1);

    // Out-of-range recovery at MODULUS=10
    step(0, 1, 2'd3, 8'h00, 8'h00, 8'd0);
    step(0, 1, 2'd0, 8'h0D, 8'h00, 8'h00);
    chk("oor_set_q10", int'(q10), 13);
    chk("oor_tc10_jk", int'(tc10), 0);
    step(0, 1, 2'd1, 8'h00, 8'h00, 8'h00);
    chk("oor_up_q10", int'(q10), 0);
    chk("oor_up_wrap10", int'(wr10), 1);
    step(0, 1, 2'd3, 8'h00, 8'h00, 8'd13);
    step(0, 1, 2'd2, 8'h00, 8'h00, 8'h00);
    chk("oor_down_q10", int'(q10), 9);
    chk("oor_down_wrap10", int'(wr10), 0);

    // Back-to-back wraps at MODULUS=2, then gating
    step(0, 1, 2'd3, 8'h00, 8'h00, 8'h00);
    step(0, 1, 2'd1, 8'h00, 8'h00, 8'h00);
    chk("m2_q_e1", int'(q2), 1);
    chk("m2_w_e1", int'(wr2), 0);
    step(0, 1, 2'd1, 8'h00, 8'h00, 8'h00);
    chk("m2_q_e2", int'(q2), 0);
    chk("m2_w_e2", int'(wr2), 1);
    step(0, 1, 2'd1, 8'h00, 8'h00, 8'h00);
    chk("m2_q_e3", int'(q2), 1);
    chk("m2_w_e3", int'(wr2), 0);
    step(0, 1, 2'd1, 8'h00, 8'h00, 8'h00);
    chk("m2_q_e4", int'(q2), 0);
    chk("m2_w_e4", int'(wr2), 1);
    step(0, 1, 2'd1, 8'h00, 8'h00, 8'h00);
    step(0, 0, 2'd1, 8'h00, 8'h00, 8'h00);
    chk("m2_gate_q", int'(q2), 1);
    chk("m2_gate_tc", int'(tc2), 1);
    chk("m2_gate_wrap", int'(wr2), 0);
    step(0, 0, 2'd1, 8'h00, 8'h00, 8'h00);
    chk("m2_gate_hold", int'(q2), 1);

    @(negedge clk);
    #1;
    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
